conv_writeback: RTL
===================

Name: conv_writeback

Overview:
- Downstream stage of the convolution accelerator core.
- Accepts the core's biased 18-bit signed accumulator results, requantizes each one to 8 bits, buffers it in a small FIFO, and writes it to output memory.
- The core produces results filter-major: all output pixels for filter 0, then all for filter 1, and so on.
- Output memory is laid out depth-innermost (address = offset + pixel*depth + filter), the same layout the core reads its input image in. A layer's output can therefore feed the next layer directly.

Parameters:
- FIFO_DEPTH, 4, number of requantized entries buffered between the accumulator and the memory port; power of two, at least 2.
- ADDR_W, 16, memory address width; matches the core's memory offsets.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches config, begins a layer
- out_dim  in  8  output width/height in pixels; layer has out_dim*out_dim pixels
- out_depth  in  9  number of filters (output channels)
- out_memory_offset  in  16  base address of the output tensor
- out_shift  in  4  arithmetic right-shift applied before saturation
- acc_valid  in  1  accumulator result valid
- acc_data  in  18  signed accumulator result (bias already added)
- acc_ready  out  1  block can accept a result this cycle
- mem_we  out  1  write strobe
- mem_addr  out  16  write address
- mem_wdata  out  8  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  layer in progress
- done  out  1  layer fully written; held until next start

Behaviour:
- Reset (rst low, asynchronous) puts every output at 0: acc_ready, mem_we, mem_addr, mem_wdata, busy, done. FIFO is emptied, counters are cleared, state goes to IDLE. Reset mid-layer aborts the layer; writes already committed are not undone.
- States and transitions:
  - IDLE: start=1 latches the config, clears done, and goes to RUN.
  - RUN: runs while accepted < total; moves to DRAIN when the last result is accepted.
  - DRAIN: moves to DONE when the FIFO is empty and no write is pending.
  - DONE: done=1; start=1 behaves as in IDLE.
- start in RUN or DRAIN is ignored.
- Layer size: total = out_dim*out_dim*out_depth, computed with a 25-bit counter. If total is 0 (out_dim=0 or out_depth=0), the block goes from start straight to DONE on the next cycle and issues no writes.
- Handshake: a result is accepted when acc_valid && acc_ready. acc_ready = busy && state==RUN && FIFO not full. acc_ready is 0 in IDLE, DRAIN and DONE; acc_valid is ignored when acc_ready is 0.
- Requantize (combinational on accept, before the FIFO push):
  - s = acc_data >>> out_shift (arithmetic).
  - Saturate s per the Optional Feature.
- Address generation (per accepted result):
  - addr starts at out_memory_offset, with pix=0 and filt=0.
  - Normal result: addr += out_depth, pix++.
  - When pix reaches out_dim*out_dim-1: pix=0, filt++, addr = out_memory_offset + filt(new).
  - Addresses wrap mod 2^16.
  - Each FIFO entry holds {addr, data}.
- Write port:
  - mem_we, mem_addr and mem_wdata are registered and present the FIFO head.
  - mem_we stays asserted, with addr/data held stable, until mem_ready=1. The entry pops on that edge.
  - Next entry appears the following cycle. Sustained rate is 1 write per cycle when mem_ready=1.
- Latency: a result accepted on edge N can drive mem_we at the earliest in the cycle after edge N (N+1).
- FIFO boundaries:
  - Full: acc_ready=0.
  - Empty: mem_we=0.
  - Push and pop in the same cycle on a full FIFO: allowed only as a pop; acc_ready is evaluated before the pop, so a full FIFO does not accept.
  - Push and pop in the same cycle on a non-full FIFO: both occur and the count is unchanged.
- busy=1 from the cycle after start until the DONE entry. done rises on the same edge that busy falls.

Optional Feature:
- Macro: WB_RELU_EN.
- Defined: s = max(s,0), then saturate to unsigned 0..255. mem_wdata is unsigned.
- Undefined: saturate s to signed -128..127. mem_wdata is two's complement.

Test Plan:
- out_dim=2, out_depth=2, offset=1000, shift=0, mem_ready=1; results 1,2,3,4,5,6,7,8 -> writes (1000,1),(1002,2),(1004,3),(1006,4),(1001,5),(1003,6),(1005,7),(1007,8); then done=1, busy=0.
- Saturation with shift=2; inputs 1000, -1000, 300, -3:
  - Without WB_RELU_EN -> 127, -128, 75, -1.
  - With WB_RELU_EN -> 250, 0, 75, 0.
- Backpressure: mem_ready=0 for 10 cycles with acc_valid held -> exactly FIFO_DEPTH results accepted, then acc_ready=0; mem_we held with stable addr/data; on mem_ready=1 data drains in order with no loss or duplication.
- Offset 65534, out_dim=1, out_depth=3 -> addresses 65534, 65535, 0 (single pixel, filter stepping wraps).
- out_depth=0 -> done=1 the cycle after start, no mem_we. A second start while busy -> ignored, counters unchanged.
- rst low mid-RUN with the FIFO holding 2 entries -> all outputs 0 immediately; after release, start runs a full layer correctly.

Source files
------------

// File: rtl/conv_writeback.sv
// conv_writeback: requantizes the core's signed accumulator results to 8 bits,
// buffers {addr, data} pairs in a small FIFO and writes them to output memory
// in depth-innermost order (addr = offset + pixel*depth + filter).
// Optional feature macro: WB_RELU_EN (ReLU + unsigned 0..255 saturation);
// when undefined, results saturate to signed -128..127.
// Handshakes: a result moves on acc_valid && acc_ready; a write completes on
// mem_we && mem_ready, with mem_addr/mem_wdata held stable until then.
module conv_writeback #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        out_dim,
    input  logic [8:0]        out_depth,
    input  logic [ADDR_W-1:0] out_memory_offset,
    input  logic [3:0]        out_shift,
    input  logic              acc_valid,
    input  logic [17:0]       acc_data,
    output logic              acc_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        o_dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 8;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t r_state, w_state_next;

    logic [24:0]       r_total, r_accepted;
    logic [15:0]       r_pix, r_pix_last;
    logic [8:0]        r_filt, r_depth;
    logic [ADDR_W-1:0] r_offset, r_addr;
    logic [3:0]        r_shift;

    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_start_ok, w_full, w_acc_ready, w_push, w_pop, w_last;
    logic [24:0]       w_total;
    logic [15:0]       w_pix_last;
    logic [8:0]        w_filt_inc;
    logic signed [17:0] w_shifted;
    logic [7:0]        w_sat;
    logic [ENT_W-1:0]  w_entry;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_rd_next;
    logic              w_head_is_new;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_total     = 25'(out_dim) * 25'(out_dim) * 25'(out_depth);
    assign w_pix_last  = 16'(out_dim) * 16'(out_dim) - 16'd1;
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    // RUN already implies busy; a full FIFO never accepts, even if it pops this cycle
    assign w_acc_ready = (r_state == S_RUN) && !w_full;
    assign w_push      = acc_valid && w_acc_ready;
    assign w_pop       = r_we && mem_ready;
    assign w_last      = w_push && (r_accepted == r_total - 25'd1);
    assign w_filt_inc  = r_filt + 9'd1;
    assign w_shifted   = $signed(acc_data) >>> r_shift;
    assign w_entry     = {r_addr, w_sat};

    assign acc_ready   = w_acc_ready;
    assign mem_we      = r_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;

    // Requantize: arithmetic shift already applied, clamp to the 8-bit output range
    always_comb begin
        w_sat = w_shifted[7:0];
`ifdef WB_RELU_EN
        if (w_shifted < 18'sd0)
            w_sat = 8'd0;
        else if (w_shifted > 18'sd255)
            w_sat = 8'd255;
`else
        if (w_shifted > 18'sd127)
            w_sat = 8'h7F;
        else if (w_shifted < -18'sd128)
            w_sat = 8'h80;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; an empty layer skips straight to DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_next = (w_total == 25'd0) ? S_DONE : S_RUN;
            S_RUN:          if (w_last) w_state_next = S_DRAIN;
            S_DRAIN:        if (r_count == '0 && !r_we) w_state_next = S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    // Latch layer config on start; step pixel/filter/address on each accepted result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_total    <= '0;
            r_accepted <= '0;
            r_pix      <= '0;
            r_pix_last <= '0;
            r_filt     <= '0;
            r_depth    <= '0;
            r_offset   <= '0;
            r_addr     <= '0;
            r_shift    <= '0;
        end else if (w_start_ok) begin
            r_total    <= w_total;
            r_accepted <= '0;
            r_pix      <= '0;
            r_pix_last <= w_pix_last;
            r_filt     <= '0;
            r_depth    <= out_depth;
            r_offset   <= out_memory_offset;
            r_addr     <= out_memory_offset;
            r_shift    <= out_shift;
        end else if (w_push) begin
            r_accepted <= r_accepted + 25'd1;
            if (r_pix == r_pix_last) begin
                r_pix  <= '0;
                r_filt <= w_filt_inc;
                r_addr <= r_offset + ADDR_W'(w_filt_inc);
            end else begin
                r_pix  <= r_pix + 16'd1;
                r_addr <= r_addr + ADDR_W'(r_depth);
            end
        end
    end

    // FIFO storage (no reset needed; occupancy is tracked by r_count)
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_entry;
    end

    assign w_count_next  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_next     = r_rd_ptr + PTR_W'(w_pop);
    assign w_head_is_new = ((r_count - CNT_W'(w_pop)) == '0);

    // FIFO pointers and the registered write port that mirrors the FIFO head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_we     <= (w_count_next != '0);
            if (w_count_next != '0) begin
                if (w_head_is_new)
                    {r_mem_addr, r_mem_wdata} <= w_entry;
                else
                    {r_mem_addr, r_mem_wdata} <= r_fifo[w_rd_next];
            end
        end
    end

endmodule
